// File: rtl/aes_key_pkg.sv
// Shared types, constants and helpers for the AES-128 reverse key schedule.
// Used by aes_key_step and aes_key_unroll.
package aes_key_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PREROLL,
      RUN
   } state_t;

   localparam int         NR         = 10;
   localparam logic [7:0] RCON_FIRST = 8'h01;
   localparam logic [7:0] RCON_LAST  = 8'h36;
   localparam logic [7:0] XTIME_POLY = 8'h1b;

   function automatic logic [31:0] rot_word(
      input logic [31:0] w
   );
      return {w[23:0], w[31:24]};
   endfunction

   // xtime: multiply by x in GF(2^8)
   function automatic logic [7:0] rcon_next(
      input logic [7:0] r
   );
      logic [7:0] s;
      s = {r[6:0], 1'b0};
      return r[7] ? (s ^ XTIME_POLY) : s;
   endfunction

   // inverse of xtime: divide by x in GF(2^8)
   function automatic logic [7:0] rcon_prev(
      input logic [7:0] r
   );
      logic [7:0] s;
      s = r ^ XTIME_POLY;
      return r[0] ? ({1'b0, s[7:1]} | 8'h80)
                  : {1'b0, r[7:1]};
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step, forward or reverse, combinational.
// Ports: w current key, rcon round constant, reverse dir, nk next key.
module aes_key_step
   import aes_key_pkg::*;
(
   input  logic [127:0] w,
   input  logic [7:0]   rcon,
   input  logic         reverse,
   output logic [127:0] nk
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] p3, sin, rw, sw, t;
   logic [31:0] f0, f1, f2, f3;
   logic [31:0] p0, p1, p2;

   assign w0 = w[127:96];
   assign w1 = w[95:64];
   assign w2 = w[63:32];
   assign w3 = w[31:0];

   // reverse path recovers the previous w3 before substitution
   assign p3  = w3 ^ w2;
   assign sin = reverse ? p3 : w3;
   assign rw  = rot_word(sin);

   for (genvar i = 0; i < 4; i++) begin : g_sb
      bSbox u_sb (
         .A       (rw[8*i +: 8]),
         .encrypt (1'b1),
         .Q       (sw[8*i +: 8])
      );
   end

   assign t = sw ^ {rcon, 24'h0};

   assign f0 = w0 ^ t;
   assign f1 = w1 ^ f0;
   assign f2 = w2 ^ f1;
   assign f3 = w3 ^ f2;

   assign p0 = w0 ^ t;
   assign p1 = w1 ^ w0;
   assign p2 = w2 ^ w1;

   assign nk = reverse ? {p0, p1, p2, p3}
                       : {f0, f1, f2, f3};

endmodule

// File: rtl/bSbox.sv
// AES S-box, forward (encrypt=1) or inverse (encrypt=0).
// Ports: A in byte, encrypt mode select, Q out substituted byte.
module bSbox (
   input  logic [7:0] A,
   input  logic       encrypt,
   output logic [7:0] Q
);

   function automatic logic [7:0] gmul(
      input logic [7:0] a,
      input logic [7:0] b
   );
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b)
                    : {aa[6:0], 1'b0};
      end
      return p;
   endfunction

   // x^254 = product of x^(2^i), i=1..7; maps 0 to 0
   function automatic logic [7:0] ginv(
      input logic [7:0] x
   );
      logic [7:0] s;
      logic [7:0] r;
      s = x;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         s = gmul(s, s);
         r = gmul(r, s);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(
      input logic [7:0] a,
      input int         k
   );
      logic [7:0] r;
      r = a;
      for (int i = 0; i < k; i++)
         r = {r[6:0], r[7]};
      return r;
   endfunction

   function automatic logic [7:0] aff(
      input logic [7:0] a
   );
      return a ^ rotl(a, 1) ^ rotl(a, 2)
               ^ rotl(a, 3) ^ rotl(a, 4)
               ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_aff(
      input logic [7:0] s
   );
      return rotl(s, 1) ^ rotl(s, 3)
           ^ rotl(s, 6) ^ 8'h05;
   endfunction

   assign Q = encrypt ? aff(ginv(A))
                      : ginv(inv_aff(A));

endmodule

// File: rtl/aes_key_unroll.sv
// AES-128 round keys for decryption, emitted round 10 down to 0.
// Ports: CLK, RST_N (sync low), start/key_is_last/key_in load;
// rk/rk_round/rk_valid/rk_ready output handshake; busy, done status.
module aes_key_unroll
   import aes_key_pkg::*;
#(
   parameter int NR = aes_key_pkg::NR
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         start,
   input  logic         key_is_last,
   input  logic [127:0] key_in,
   output logic [127:0] rk,
   output logic [3:0]   rk_round,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic         busy,
   output logic         done
);

   if (NR != 10) begin : g_bad_nr
      $error("aes_key_unroll supports only NR=10");
   end

   localparam logic [3:0] LAST_RND = 4'(NR);

   state_t       state, state_n;
   logic [127:0] rk_n, step_k;
   logic [3:0]   rnd_n;
   logic [7:0]   rcon, rcon_n;
   logic         done_n;

   aes_key_step u_step (
      .w       (rk),
      .rcon    (rcon),
      .reverse (state == RUN),
      .nk      (step_k)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state    <= IDLE;
         rk       <= '0;
         rk_round <= '0;
         rcon     <= 8'h00;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         rk       <= rk_n;
         rk_round <= rnd_n;
         rcon     <= rcon_n;
         done     <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      rk_n    = rk;
      rnd_n   = rk_round;
      rcon_n  = rcon;
      done_n  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               rk_n = key_in;
               if (key_is_last) begin
                  rcon_n  = RCON_LAST;
                  rnd_n   = LAST_RND;
                  state_n = RUN;
               end else begin
                  rcon_n  = RCON_FIRST;
                  rnd_n   = 4'd0;
                  state_n = PREROLL;
               end
            end
         end
         PREROLL: begin
            rk_n  = step_k;
            rnd_n = rk_round + 4'd1;
            if (rk_round == LAST_RND - 4'd1) begin
               rcon_n  = RCON_LAST;
               state_n = RUN;
            end else begin
               rcon_n = rcon_next(rcon);
            end
         end
         RUN: begin
            if (rk_ready) begin
               if (rk_round != 4'd0) begin
                  rk_n   = step_k;
                  rcon_n = rcon_prev(rcon);
                  rnd_n  = rk_round - 4'd1;
               end else begin
                  done_n  = 1'b1;
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy     = (state != IDLE);
   assign rk_valid = (state == RUN);

endmodule

// File: tb/tb_aes_key_unroll.sv
// Scoreboard bench for aes_key_unroll.
// Known-answer keys queued at start, compared on every valid cycle.
module tb_aes_key_unroll;

   logic         CLK = 1'b0;
   logic         RST_N = 1'b0;
   logic         start = 1'b0;
   logic         key_is_last = 1'b0;
   logic [127:0] key_in = '0;
   logic [127:0] rk;
   logic [3:0]   rk_round;
   logic         rk_valid;
   logic         rk_ready = 1'b0;
   logic         busy;
   logic         done;

   always #5 CLK = ~CLK;

   aes_key_unroll dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .start       (start),
      .key_is_last (key_is_last),
      .key_in      (key_in),
      .rk          (rk),
      .rk_round    (rk_round),
      .rk_valid    (rk_valid),
      .rk_ready    (rk_ready),
      .busy        (busy),
      .done        (done)
   );

   typedef struct {
      logic [3:0]   rnd;
      logic [127:0] key;
      bit           chk;
   } exp_t;

   localparam logic [127:0] ZK10 =
      128'hb4ef5bcb3e92e21123e951cf6f8f188e;
   localparam logic [127:0] ZK1 =
      128'h62636363626363636263636362636363;

   logic [127:0] fips [0:10];
   exp_t         sbq [$];
   exp_t         mon_e;
   int           n_chk = 0;
   int           n_fail = 0;
   int           cyc = 0;
   int           start_cyc = 0;
   int           hs_total = 0;
   int           done_total = 0;
   bit           prev_done = 0;
   bit           bp_mode = 0;
   bit           ready_lvl = 0;
   int           stall_left = 0;
   bit [15:0]    stalled_rnd = '0;

   task automatic check(
      input string        tag,
      input logic [127:0] got,
      input logic [127:0] exp
   );
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
      end
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   // rk_ready: level, or random with 5-cycle stalls at 10, 5, 0
   always @(posedge CLK) begin
      #1;
      if (!bp_mode) begin
         rk_ready = ready_lvl;
      end else if (stall_left > 0) begin
         rk_ready = 1'b0;
         stall_left--;
      end else if (rk_valid &&
                   (rk_round == 4'd10 ||
                    rk_round == 4'd5 ||
                    rk_round == 4'd0) &&
                   !stalled_rnd[rk_round]) begin
         stalled_rnd[rk_round] = 1'b1;
         stall_left = 4;
         rk_ready = 1'b0;
      end else begin
         rk_ready = 1'($urandom_range(0, 1));
      end
   end

   // compare every valid cycle with the queue head; pop on handshake
   always @(negedge CLK) begin
      if (RST_N) begin
         if (rk_valid) begin
            if (sbq.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_rk: got %h round %0d expected none",
                        rk, rk_round);
            end else begin
               mon_e = sbq[0];
               check("rk_round", 128'(rk_round), 128'(mon_e.rnd));
               if (mon_e.chk)
                  check("rk", rk, mon_e.key);
               if (rk_ready) begin
                  void'(sbq.pop_front());
                  hs_total++;
               end
            end
         end
         if (done) begin
            done_total++;
            check("done_1cyc", 128'(prev_done), 128'(0));
         end
         prev_done = done;
      end else begin
         prev_done = 0;
      end
   end

   task automatic push_seq(input bit zero);
      exp_t e;
      for (int r = 10; r >= 0; r--) begin
         e.rnd = 4'(r);
         if (zero) begin
            e.key = (r == 10) ? ZK10 :
                    (r == 1)  ? ZK1  : '0;
            e.chk = (r == 10 || r == 1 || r == 0);
         end else begin
            e.key = fips[r];
            e.chk = 1'b1;
         end
         sbq.push_back(e);
      end
   endtask

   task automatic run_key(
      input logic [127:0] k,
      input bit           last,
      input bit           zero
   );
      key_in      = k;
      key_is_last = last;
      start       = 1'b1;
      push_seq(zero);
      @(posedge CLK);
      #1;
      start     = 1'b0;
      start_cyc = cyc;
      check("busy_after_start", 128'(busy), 128'(1));
   endtask

   task automatic pulse_start(
      input logic [127:0] k,
      input bit           last
   );
      key_in      = k;
      key_is_last = last;
      start       = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      check("busy_ignored_start", 128'(busy), 128'(1));
   endtask

   task automatic wait_valid(input int exp_lat);
      for (int i = 0; i < 40 && !rk_valid; i++) begin
         @(posedge CLK);
         #1;
      end
      check("latency", 128'(cyc - start_cyc), 128'(exp_lat));
   endtask

   task automatic wait_round(input int r);
      for (int i = 0; i < 60; i++) begin
         if (rk_valid && rk_round == 4'(r)) break;
         @(posedge CLK);
         #1;
      end
      check("reach_round", 128'(rk_round), 128'(r));
   endtask

   task automatic wait_done();
      bit seen;
      seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(posedge CLK);
         #1;
         seen = done;
      end
      check("done_seen", 128'(seen), 128'(1));
      check("sb_empty", 128'(sbq.size()), 128'(0));
   endtask

   initial begin
      int hs0;
      fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
      fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      ready_lvl = 1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_rk_valid", 128'(rk_valid), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_rk", rk, 128'(0));
      check("rst_rk_round", 128'(rk_round), 128'(0));
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      @(posedge CLK);
      #1;

      // cipher key with pre-roll, then back-to-back last-key load
      run_key(fips[0], 1'b0, 1'b0);
      wait_valid(10);
      wait_done();
      run_key(fips[10], 1'b1, 1'b0);
      wait_valid(0);
      wait_done();
      @(negedge CLK);
      check("idle_busy", 128'(busy), 128'(0));
      check("idle_valid", 128'(rk_valid), 128'(0));
      check("round0_hold", rk, fips[0]);

      // random backpressure with forced stalls
      bp_mode     = 1;
      stalled_rnd = '0;
      hs0         = hs_total;
      run_key(fips[0], 1'b0, 1'b0);
      wait_valid(10);
      wait_done();
      bp_mode = 0;
      check("bp_handshakes", 128'(hs_total - hs0), 128'(11));
      check("bp_stalls", 128'(stalled_rnd), 128'(16'h0421));

      // start during PREROLL and during RUN is ignored
      run_key(fips[0], 1'b0, 1'b0);
      repeat (3) begin
         @(posedge CLK);
         #1;
      end
      pulse_start('0, 1'b1);
      wait_valid(10);
      wait_round(7);
      pulse_start('0, 1'b0);
      wait_done();

      // reset in the middle of RUN
      run_key(fips[10], 1'b1, 1'b0);
      wait_valid(0);
      wait_round(6);
      RST_N = 1'b0;
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      sbq.delete();
      @(negedge CLK);
      check("mid_rst_valid", 128'(rk_valid), 128'(0));
      check("mid_rst_busy", 128'(busy), 128'(0));
      check("mid_rst_rk", rk, 128'(0));
      check("mid_rst_round", 128'(rk_round), 128'(0));
      @(posedge CLK);
      #1;
      run_key(fips[0], 1'b0, 1'b0);
      wait_valid(10);
      wait_done();

      // all-zero cipher key
      run_key('0, 1'b0, 1'b1);
      wait_valid(10);
      wait_done();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("done_total", 128'(done_total), 128'(6));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
